// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential popcount engine.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  // Count width needed to hold 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount_seq_lut4.sv
// 4-bit nibble popcount lookup (the LUT_4 table): number of set bits in addr.
module popcount_seq_lut4 (
  input  logic [3:0] addr,
  output logic [2:0] val
);

  always_comb begin
    val = 3'd0;
    case (addr)
      4'h0:                         val = 3'd0;
      4'h1, 4'h2, 4'h4, 4'h8:       val = 3'd1;
      4'h3, 4'h5, 4'h6, 4'h9,
      4'hA, 4'hC:                   val = 3'd2;
      4'h7, 4'hB, 4'hD, 4'hE:       val = 3'd3;
      4'hF:                         val = 3'd4;
      default:                      val = 3'd0;
    endcase
  end

endmodule

// File: rtl/popcount_seq.sv
// Sequential popcount: one nibble per cycle through the 4-bit lookup, result held until taken.
// Optional POPCNT_EARLY_EXIT_EN stops scanning once the remaining word is all zero.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int CNT_W  = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              parity,
  output logic              busy
);

  localparam int NIB   = DATA_W / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         nib_cnt;
  logic [DATA_W-1:0]  shreg_nxt;

  popcount_seq_lut4 u_lut_4 (
    .addr (shreg_q[NIB_W-1:0]),
    .val  (nib_cnt)
  );

  assign shreg_nxt = shreg_q >> NIB_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = data_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
`ifdef POPCNT_EARLY_EXIT_EN
          if (data_in == '0) state_d = HOLD;
`endif
        end
      end
      SCAN: begin
        acc_d   = acc_q + CNT_W'(nib_cnt);
        shreg_d = shreg_nxt;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NIB - 1)) state_d = HOLD;
`ifdef POPCNT_EARLY_EXIT_EN
        // Nothing left to count: remaining nibbles would all add zero.
        if (shreg_nxt == '0) state_d = HOLD;
`endif
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // count tracks acc, which is only cleared on the next accept, so it persists after HOLD.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign count     = acc_q;
  assign parity    = acc_q[0];

endmodule

// File: tb/tb_popcount_seq.sv
// Directed + random bench for popcount_seq against a bit-counting reference model.
module tb_popcount_seq;

  localparam int DW  = 16;
  localparam int CW  = 5;
  localparam int NIB = DW / 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          parity;
  logic          busy;

  int total = 0;
  int bad   = 0;

  popcount_seq #(.DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .parity    (parity),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_count(input logic [DW-1:0] w);
    int n = 0;
    for (int i = 0; i < DW; i++) n += int'(w[i]);
    return n;
  endfunction

  // Edges from the accept edge until out_valid is visible.
  function automatic int ref_latency(input logic [DW-1:0] w);
`ifdef POPCNT_EARLY_EXIT_EN
    int hi = -1;
    for (int k = 0; k < NIB; k++) if (((w >> (4 * k)) & 16'hF) != 0) hi = k;
    return (hi < 0) ? 0 : hi + 1;
`else
    return NIB;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept w, wait for the result, optionally stall the consumer for hold cycles, then drain.
  task automatic run_word(input logic [DW-1:0] w, input int hold, input string tag);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    data_in   = w;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    data_in  = DW'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    check({tag, "_lat"},    32'(lat),    32'(ref_latency(w)));
    check({tag, "_count"},  32'(count),  32'(ref_count(w)));
    check({tag, "_parity"}, 32'(parity), 32'(ref_count(w) % 2));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      data_in  = DW'($urandom);
      step();
      check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_c"}, 32'(count),     32'(ref_count(w)));
      check({tag, "_hold_r"}, 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, "_drop_v"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_r"}, 32'(in_ready),  32'd1);
    check({tag, "_keep_c"}, 32'(count),     32'(ref_count(w)));
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] w;
    reset = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",    32'(count),     32'd0);
    check("rst_parity",   32'(parity),    32'd0);
    check("rst_busy",     32'(busy),      32'd0);

    run_word(16'hFFFF, 0, "ffff");

    // Back-to-back: second word waits on in_valid until the first result is handed off.
    in_valid = 1'b1; data_in = 16'hA5C3; out_ready = 1'b1;
    step();
    data_in = 16'h0001;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("b2b_lat1",   32'(n),     32'(ref_latency(16'hA5C3)));
    check("b2b_cnt1",   32'(count), 32'd8);
    check("b2b_par1",   32'(parity), 32'd0);
    step(); n++;
    check("b2b_idle",   32'(in_ready), 32'd1);
    step(); n++;
    in_valid = 1'b0;
    while (!out_valid && n < 30) begin step(); n++; end
    check("b2b_lat2",   32'(n),      32'(ref_latency(16'hA5C3) + 2 + ref_latency(16'h0001)));
    check("b2b_cnt2",   32'(count),  32'd1);
    check("b2b_par2",   32'(parity), 32'd1);
    step();
    out_ready = 1'b0;

    run_word(16'h8000, 5, "stall");
    step();
    check("stall_no_accept", 32'(busy), 32'd0);

    // Reset during the second SCAN cycle discards the word.
    in_valid = 1'b1; data_in = 16'h0F0F; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy",  32'(busy),     32'd0);
    check("mid_rst_count", 32'(count),    32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) n++;
      step();
    end
    check("mid_rst_no_valid", 32'(n), 32'd0);
    run_word(16'h0003, 0, "after_rst");

    run_word(16'h0000, 0, "zero");
    run_word(16'h0011, 0, "w0011");

    for (int i = 0; i < 20; i++) begin
      w = DW'($urandom);
      if (i % 5 == 0) w &= 16'h00F0;
      run_word(w, int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
